// File: rtl/conv_acc_ctrl.sv
// -----------------------------------------------------------------------------
// conv_acc_ctrl
// Sequencer for the CNN partial-sum datapath. For each output window it
// clears the four lane accumulators, streams KLEN operand reads, raises
// add_en one cycle behind each read (to match the 1-cycle memory latency),
// and then offers the reduced result downstream on a valid/ready handshake.
// A run covers num_win windows and ends with a one-cycle done pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      begin a run (only looked at while idle)
//   num_win    number of windows in the run, captured when start is accepted
//   busy       high whenever the sequencer is not idle
//   acc_clr    accumulator clear strobe
//   rd_en      operand memory read enable
//   rd_addr    operand memory read address (free-running, wraps)
//   add_en     accumulator add enable (rd_en delayed by one cycle)
//   out_valid  reduced result is valid
//   out_ready  downstream accepts the result
//   wr_idx     index of the window currently offered
//   done       one-cycle pulse at the end of a run
// -----------------------------------------------------------------------------
module conv_acc_ctrl #(
  parameter int KLEN   = 16,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_win,
  output logic              busy,
  output logic              acc_clr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              add_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  wr_idx,
  output logic              done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_ACCUM  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

  // Term counter only needs to reach KLEN-1.
  localparam int K_W = (KLEN > 1) ? $clog2(KLEN) : 1;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [K_W-1:0]   k_cnt;
  logic [CNT_W-1:0] num_win_q;

  logic accept;    // start taken in IDLE with a non-empty run
  logic empty_run; // start taken in IDLE with num_win == 0
  logic transfer;  // result handed downstream this cycle
  logic last_win;  // the window on offer is the final one of the run
  logic last_term; // final read of the current window

  assign accept    = (state == S_IDLE) && start && (num_win != '0);
  assign empty_run = (state == S_IDLE) && start && (num_win == '0);
  assign transfer  = (state == S_OUT) && out_ready;
  assign last_win  = (wr_idx == (num_win_q - CNT_W'(1)));
  assign last_term = (k_cnt == K_W'(KLEN - 1));

  // NOTE: every combinational output gets a default before the case so that
  // no path leaves it unassigned; otherwise a latch would be inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = S_ACCUM;
      S_ACCUM:  if (last_term) state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_OUT;
      S_OUT:    if (out_ready) state_nxt = last_win ? S_IDLE : S_CLEAR;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so that each strobe lines up
  // with the state it belongs to, with no decode glitches on the ports.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k_cnt     <= '0;
      num_win_q <= '0;
      busy      <= 1'b0;
      acc_clr   <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      add_en    <= 1'b0;
      out_valid <= 1'b0;
      wr_idx    <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != S_IDLE);
      acc_clr   <= (state_nxt == S_CLEAR);
      rd_en     <= (state_nxt == S_ACCUM);
      out_valid <= (state_nxt == S_OUT);
      // Read data arrives one cycle after rd_en, so the add follows it.
      add_en    <= rd_en;
      done      <= empty_run || (transfer && last_win);

      if (state == S_ACCUM) k_cnt <= k_cnt + K_W'(1);
      else                  k_cnt <= '0;

      // The address is not rewound between windows: window w starts where
      // window w-1 stopped, i.e. at w*KLEN modulo the address space.
      if (accept)                rd_addr <= '0;
      else if (state == S_ACCUM) rd_addr <= rd_addr + ADDR_W'(1);

      if (accept) begin
        num_win_q <= num_win;
        wr_idx    <= '0;
      end else if (transfer && !last_win) begin
        wr_idx    <= wr_idx + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_conv_acc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv_acc_ctrl
// Drives conv_acc_ctrl with directed and random runs. A surrounding datapath
// (operand memory, four 12-bit lane accumulators, 4-way reducer) is modelled
// so the reduced result of every window can be compared with the sum of the
// operand words the window should have covered. Expected control outputs
// come from a timeline model: each window is a CLEAR cycle, KLEN reads, a
// settle cycle and an output phase that lasts until the handshake.
// -----------------------------------------------------------------------------
module tb_conv_acc_ctrl;

  localparam int K      = 4;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  num_win = '0;
  logic              busy;
  logic              acc_clr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              add_en;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CNT_W-1:0]  wr_idx;
  logic              done;

  conv_acc_ctrl #(.KLEN(K), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_win(num_win), .busy(busy),
    .acc_clr(acc_clr), .rd_en(rd_en), .rd_addr(rd_addr), .add_en(add_en),
    .out_valid(out_valid), .out_ready(out_ready), .wr_idx(wr_idx), .done(done)
  );

  always #5 clk = ~clk;

  // ---------------- surrounding datapath ----------------
  logic [7:0]  mem  [DEPTH][4];
  logic [7:0]  rd_q [4];
  logic [11:0] acc  [4];
  logic [13:0] total;
  logic [7:0]  red;

  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (rd_en) rd_q[l] <= mem[rd_addr][l];
      if (acc_clr || rst) acc[l] <= '0;
      else if (add_en)    acc[l] <= acc[l] + 12'(rd_q[l]);
    end
  end

  assign total = 14'(acc[0]) + 14'(acc[1]) + 14'(acc[2]) + 14'(acc[3]);
  assign red   = total[11:4];

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Window sum straight from the operand words it covers.
  function automatic int exp_red(input int w);
    int tot = 0;
    for (int l = 0; l < 4; l++) begin
      int s = 0;
      for (int i = 0; i < K; i++) s += int'(mem[(w * K + i) % DEPTH][l]);
      tot += s & 12'hfff;
    end
    return (tot >> 4) & 8'hff;
  endfunction

  // ---------------- timeline model ----------------
  // m_t counts cycles since the window's CLEAR cycle.
  bit m_idle = 1'b1;
  bit m_done = 1'b0;
  bit m_just_reset = 1'b1;
  int m_win = 0;
  int m_n   = 0;
  int m_t   = 0;
  int last_red = -1;

  function automatic bit m_ov();
    return !m_idle && (m_t >= K + 2);
  endfunction

  task automatic check_outputs();
    bit e_clr, e_rd, e_add, e_ov;
    e_clr = !m_idle && (m_t == 0);
    e_rd  = !m_idle && (m_t >= 1) && (m_t <= K);
    e_add = !m_idle && (m_t >= 2) && (m_t <= K + 1);
    e_ov  = m_ov();
    check("ctrl{busy,clr,rd,add,ov,done}",
          32'({busy, acc_clr, rd_en, add_en, out_valid, done}),
          32'({!m_idle, e_clr, e_rd, e_add, e_ov, m_done}));
    if (e_rd) check("rd_addr", 32'(rd_addr), 32'((m_win * K + m_t - 1) % DEPTH));
    if (e_ov) begin
      check("wr_idx", 32'(wr_idx), 32'(m_win));
      check("reduced", 32'(red), 32'(exp_red(m_win)));
      last_red = int'(red);
    end
    if (m_just_reset) begin
      check("rst_rd_addr", 32'(rd_addr), 32'd0);
      check("rst_wr_idx", 32'(wr_idx), 32'd0);
    end
  endtask

  task automatic model_step(input bit s, input int nw, input bit rdy, input bit r);
    if (r) begin
      m_idle = 1'b1; m_done = 1'b0; m_just_reset = 1'b1; m_t = 0;
    end else begin
      m_just_reset = 1'b0;
      m_done = 1'b0;
      if (m_idle) begin
        if (s) begin
          if (nw == 0) m_done = 1'b1;
          else begin m_idle = 1'b0; m_n = nw; m_win = 0; m_t = 0; end
        end
      end else if (m_ov()) begin
        if (rdy) begin
          if (m_win == m_n - 1) begin m_idle = 1'b1; m_done = 1'b1; end
          else begin m_win++; m_t = 0; end
        end
      end else begin
        m_t++;
      end
    end
  endtask

  // One clock: check the current outputs, then apply inputs for the next edge.
  task automatic cyc(input bit s, input int nw, input bit rdy, input bit r);
    @(negedge clk);
    check_outputs();
    start     = s;
    num_win   = CNT_W'(nw);
    out_ready = rdy;
    rst       = r;
    model_step(s, nw, rdy, r);
  endtask

  // Run the model's current run to completion (bounded).
  task automatic run_out(input int ready_pct, input bit junk_start);
    int i;
    for (i = 0; i < 2000 && !m_idle; i++)
      cyc(junk_start ? 1'b1 : 1'b0, int'($urandom_range(1, 9)),
          $urandom_range(99) < ready_pct, 1'b0);
    check("run_bounded", 32'(m_idle), 32'd1);
  endtask

  initial begin
    int first_ov, first_done, hold, stalls;
    bit rdy;

    for (int a = 0; a < DEPTH; a++)
      for (int l = 0; l < 4; l++) mem[a][l] = 8'($urandom);

    // Reset state.
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);

    // Basic run: words 10,20,30,40 in every lane -> (4*100)>>4 = 25.
    for (int a = 0; a < K; a++)
      for (int l = 0; l < 4; l++) mem[a][l] = 8'(10 * (a + 1));
    cyc(1, 1, 1, 0);
    first_ov = -1; first_done = -1;
    for (int j = 1; j <= 12; j++) begin
      cyc(0, 0, 1, 0);
      if (out_valid && first_ov < 0) first_ov = j;
      if (done && first_done < 0) first_done = j;
    end
    check("basic_ov_cycle", 32'(first_ov), 32'(K + 3));
    check("basic_done_cycle", 32'(first_done), 32'(K + 4));
    check("basic_red", 32'(last_red), 32'd25);

    // Multi-window, ready always high.
    cyc(1, 3, 1, 0);
    run_out(100, 1'b0);

    // done and start in the same cycle: start is accepted.
    cyc(1, 2, 1, 0);
    check("start_on_done", 32'(busy), 32'(0)); // previous run's done cycle, not yet busy
    run_out(100, 1'b0);

    // Backpressure: 5 stall cycles in window 0.
    cyc(0, 0, 1, 0);
    cyc(1, 2, 0, 0);
    hold = 0; stalls = 0;
    for (int i = 0; i < 200 && !m_idle; i++) begin
      rdy = 1'b1;
      if (m_ov() && m_win == 0 && stalls < 5) begin rdy = 1'b0; stalls++; end
      cyc(0, 0, rdy, 0);
      if (out_valid && wr_idx == 0) hold++;
    end
    check("bp_hold_cycles", 32'(hold), 32'd6);

    // Empty run: done only, never busy.
    cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);

    // Address wrap across windows.
    cyc(1, 6, 1, 0);
    run_out(100, 1'b0);

    // Reset mid-ACCUM in window 1, then a fresh run.
    cyc(0, 0, 1, 0);
    cyc(1, 3, 1, 0);
    for (int i = 0; i < 100 && !(m_win == 1 && m_t == 3); i++) cyc(0, 0, 1, 0);
    check("rst_point_reached", 32'(m_win == 1 && m_t == 3), 32'd1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    cyc(1, 1, 1, 0);
    run_out(100, 1'b0);

    // Start while busy is ignored.
    cyc(0, 0, 1, 0);
    cyc(1, 2, 1, 0);
    run_out(60, 1'b1);

    // Random runs with random backpressure and occasional reset.
    for (int r = 0; r < 40; r++) begin
      int pct;
      pct = int'($urandom_range(30, 100));
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) cyc(0, 0, 1, 0);
      cyc(1, int'($urandom_range(0, 5)), 1, 0);
      for (int i = 0; i < 2000 && !m_idle; i++)
        cyc($urandom_range(1), int'($urandom_range(0, 9)),
            $urandom_range(99) < pct, $urandom_range(99) == 0);
      check("rand_run_bounded", 32'(m_idle), 32'd1);
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
